// File: rtl/vsa_pkg.sv
// Shared widths, state encoding and payload types for the VSA program/data memory.
package vsa_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 5;
    localparam int unsigned INSTR_W   = 12;
    localparam int unsigned MEM_DEPTH = 32;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } vsa_state_e;

    // LW to R0: harmless filler fed to the core while no program image is ready.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;

    typedef struct packed {
        logic               en;
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } imem_wr_t;

endpackage

// File: rtl/vsa_loader.sv
// LOAD/RUN sequencer: accepts loader words into imem and tells the core when it may run.
module vsa_loader
    import vsa_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load_start,
    input  logic               i_load_valid,
    input  logic [INSTR_W-1:0] i_load_data,
    input  logic               i_load_last,
    output imem_wr_t           o_imem_wr_c,
    output logic               o_load_ready,
    output logic               o_run
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);

    vsa_state_e        r_state;
    logic [ADDR_W-1:0] r_load_ptr;
    vsa_state_e        w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;

    // State register; handshake outputs are registered copies of the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD;
            r_load_ptr   <= '0;
            o_load_ready <= 1'b1;
            o_run        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_ptr   <= w_ptr_nxt;
            o_load_ready <= (w_state_nxt == LOAD);
            o_run        <= (w_state_nxt == RUN);
        end
    end

    // Next-state and imem write request; load_start wins over a word offered in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_load_ptr;
        o_imem_wr_c.en   = 1'b0;
        o_imem_wr_c.addr = r_load_ptr;
        o_imem_wr_c.data = i_load_data;
        case (r_state)
            LOAD: begin
                if (i_load_start) begin
                    w_ptr_nxt = '0;
                end else if (i_load_valid) begin
                    o_imem_wr_c.en = 1'b1;
                    if (i_load_last || (r_load_ptr == LAST_PTR)) begin
                        w_state_nxt = RUN;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = ADDR_W'(r_load_ptr + 1'b1);
                    end
                end
            end
            RUN: begin
                if (i_load_start) begin
                    w_state_nxt = LOAD;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_ptr_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/vsa_mem.sv
// Instruction and data memory for the 12-bit VSA core, with a streaming program loader.
module vsa_mem
    import vsa_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] instruction,
    input  logic [ADDR_W-1:0]  ALUOutput,
    input  logic [DATA_W-1:0]  dataout,
    input  logic               wr,
    output logic [DATA_W-1:0]  datain,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               run,
    output logic               wr_err
);

    logic [INSTR_W-1:0] r_imem [MEM_DEPTH];
    logic [DATA_W-1:0]  r_dmem [MEM_DEPTH];
    imem_wr_t           w_imem_wr;
    logic               w_run;

    vsa_loader u_loader (
        .clock        (clock),
        .reset        (reset),
        .i_load_start (load_start),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .i_load_last  (load_last),
        .o_imem_wr_c  (w_imem_wr),
        .o_load_ready (load_ready),
        .o_run        (w_run)
    );

    assign run = w_run;

    // Program store; reset wipes the whole image so a partial load cannot survive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_imem[i] <= '0;
            end
        end else if (w_imem_wr.en) begin
            r_imem[w_imem_wr.addr] <= w_imem_wr.data;
        end
    end

    // Data store; core stores only land while running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_dmem[i] <= '0;
            end
        end else if (wr && w_run) begin
            r_dmem[ALUOutput] <= dataout;
        end
    end

    // Sticky record of a store issued while the program image was not ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else if (wr && !w_run) begin
            wr_err <= 1'b1;
        end
    end

    assign instruction = w_run ? r_imem[PC] : NOP_INSTR;
    assign datain      = r_dmem[ALUOutput];

endmodule

// File: doc/vsa_mem.md
VSA_MEM -- requirements
Module: vsa_mem

Interface
REQ-001 Parameters: none; all widths are fixed by the 12-bit VSA core (5-bit address/data, 12-bit instruction).
REQ-002 clock  input  1  master clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 PC  input  5  instruction fetch address from core.
REQ-005 instruction  output  12  instruction word returned to core.
REQ-006 ALUOutput  input  5  data memory address from core.
REQ-007 dataout  input  5  store data from core.
REQ-008 wr  input  1  store strobe from core (high during core MEM state of SW).
REQ-009 datain  output  5  load data returned to core.
REQ-010 load_start  input  1  request to (re)enter program-load mode.
REQ-011 load_valid  input  1  loader word valid.
REQ-012 load_data  input  12  loader instruction word.
REQ-013 load_last  input  1  marks final loader word.
REQ-014 load_ready  output  1  responder accepts loader words.
REQ-015 run  output  1  program image complete; core may execute.
REQ-016 wr_err  output  1  sticky flag: store attempted while not in RUN.

Function
REQ-017 Storage: imem 32 x 12 bits, dmem 32 x 5 bits.
REQ-018 FSM states LOAD and RUN; reset enters LOAD.
REQ-019 LOAD: load_ready=1, run=0; transfer occurs on an edge with load_valid & load_ready; imem[load_ptr] <= load_data, load_ptr increments (5 bits).
REQ-020 LOAD -> RUN on the edge accepting a word with load_last=1, or accepting the word at load_ptr=31; load_ptr returns to 0.
REQ-021 Words not written during a load keep their previous contents.
REQ-022 RUN: load_ready=0, run=1; load_valid ignored.
REQ-023 RUN -> LOAD on the edge where load_start=1; load_ptr cleared to 0; load_start in LOAD resets load_ptr to 0 without leaving LOAD.
REQ-024 instruction = imem[PC] combinationally in RUN; 12'h000 (LW to R0, no architectural effect) in LOAD.
REQ-025 datain = dmem[ALUOutput] combinationally in all states.
REQ-026 Store: in RUN, wr=1 writes dmem[ALUOutput] <= dataout on the rising edge; read in the same cycle returns the old value.
REQ-027 Store and load_start on the same RUN edge: store completes, then state becomes LOAD.
REQ-028 wr=1 in LOAD: no dmem write, wr_err set to 1; wr_err clears only on reset.
REQ-029 Address arithmetic wraps modulo 32; no out-of-range condition exists.

Reset
REQ-030 Asserting reset immediately forces: state LOAD, load_ptr 0, load_ready 1, run 0, wr_err 0, every dmem entry 0, every imem entry 0; instruction reads 12'h000.
REQ-031 Reset asserted mid-load discards the partial image; loading restarts at address 0 after reset deasserts.

Structure
REQ-032 Shared package vsa_pkg holds the widths (ADDR_W=5, DATA_W=5, INSTR_W=12), the memory depth (32), the state enum {LOAD, RUN}, and the NOP instruction constant 12'h000.
REQ-033 One sub-module, vsa_loader, holds the LOAD/RUN FSM, load_ptr and handshake; vsa_mem holds the arrays and core-side ports.

Verification
REQ-034 Reset, then 3 words 12'h801,12'h802,12'hC03 with last on the third -> imem[0..2] loaded, run=1 the next cycle, PC=2 gives instruction 12'hC03.
REQ-035 Send 32 words with load_last=0 -> transition to RUN after word 31, load_ready=0; a 33rd load_valid is ignored.
REQ-036 RUN, wr=1, ALUOutput=5, dataout=17 -> datain at address 5 reads 17 from the next cycle, and reads 0 in the write cycle.
REQ-037 LOAD, wr=1, ALUOutput=4, dataout=9 -> dmem[4] stays 0, wr_err=1 and remains 1 until reset.
REQ-038 RUN with wr=1 and load_start=1 on the same edge -> store applied, state LOAD, instruction=12'h000; reload of 1 word updates only imem[0].
REQ-039 Reset asserted after 2 of 4 words -> all outputs at reset values immediately; imem is all zero after reset.
